lbp_host_mem: RTL and testbench
===============================

Name: lbp_host_mem

Overview:
Memory-side responder for the LBP engine's gray-read / lbp-write interface. It loads an 8x8 gray image from a byte stream and holds the LBP engine in reset while loading. It then serves the engine's gray reads, captures its LBP writes, and on finish streams the 64-byte LBP result image out. It sits between the host stream fabric and the LBP engine, replacing the bench-side gray/LBP memories.

Parameters:
IMG_W, 8, image width and height in pixels.
PIX_W, 8, pixel and LBP data width.
ADDR_W, 6, address width; memory depth is IMG_W*IMG_W = 64.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous reset, active-low.
in_valid  in  1  load-stream byte valid.
in_ready  out  1  load-stream ready.
in_data  in  PIX_W  gray pixel, raster order starting at address 0.
core_rst  out  1  active-high reset to the LBP engine.
gray_addr  in  ADDR_W  engine read address.
gray_req  in  1  engine read request.
gray_data  out  PIX_W  read data.
lbp_addr  in  ADDR_W  engine write address.
lbp_write  in  1  engine write strobe.
lbp_data  in  PIX_W  engine write data.
finish  in  1  engine done pulse.
out_valid  out  1  result-stream valid.
out_ready  in  1  result-stream ready.
out_data  out  PIX_W  LBP result byte, raster order.
out_last  out  1  high with the byte at address 63.
wr_err  out  1  sticky illegal-write flag.

Behaviour:
- State machine has three states: LOAD, RUN, UNLOAD. Reset enters LOAD.
- Reset values:
  - state LOAD, load/unload counters 0, written-mask 0.
  - core_rst 1, in_ready 1, out_valid 0, out_last 0, wr_err 0, gray_data 0.
  - Image array contents are not cleared.
- LOAD:
  - in_ready = 1 (combinational from state).
  - Each edge with in_valid & in_ready writes img[cnt] <= in_data and increments cnt.
  - On the transfer at cnt == 63: cnt wraps to 0, the written-mask clears, and the state moves to RUN. core_rst falls on that same edge. in_ready is 0 from the next cycle.
  - core_rst = 1 throughout LOAD.
- RUN:
  - gray_data = img[gray_addr] combinationally while gray_req = 1, zero-latency read; 0 when gray_req = 0 or state != RUN.
  - Each edge with lbp_write = 1: if lbp_addr is interior (row 1..6 and col 1..6), lbp_mem[lbp_addr] <= lbp_data and mask[lbp_addr] <= 1.
  - A write to a border address is ignored and sets wr_err.
  - finish sampled 1 on an edge: state goes to UNLOAD and core_rst goes to 1 on that edge. A write coincident with finish is still captured.
- Writes outside RUN: lbp_write sampled 1 in LOAD or UNLOAD is ignored and sets wr_err.
- wr_err clears only on reset.
- UNLOAD:
  - out_valid = 1.
  - out_data = lbp_mem[cnt] if mask[cnt] == 1, else 0. Border bytes are therefore always 0.
  - out_last = (cnt == 63).
  - Each edge with out_valid & out_ready increments cnt. out_data holds stable while out_ready = 0.
  - The transfer with out_last goes to LOAD, cnt = 0; in_ready is 1 next cycle.
- Ignored inputs:
  - finish outside RUN is ignored.
  - gray_req outside RUN returns 0.
  - in_valid outside LOAD is not accepted.
- Reset mid-operation: asynchronous return to LOAD with all reset values.
  - A partially loaded image must be fully reloaded (64 bytes).
  - Partial LBP results are discarded via the mask clear on the next LOAD->RUN transition.
- Simultaneous lbp_write to the same address on consecutive edges: last write wins.

Test Plan:
- Load pixel[i] = i for i = 0..63 -> in_ready high for 64 accepted beats then low. core_rst falls on the 64th transfer edge. gray_req = 1 with gray_addr = 27 -> gray_data = 27; gray_req = 0 -> gray_data = 0.
- In RUN, write lbp_addr = 9 data 0xA5 and lbp_addr = 54 data 0x3C, then pulse finish -> UNLOAD; with out_ready = 1 the stream is byte 9 = 0xA5, byte 54 = 0x3C, all others 0, out_last only on byte 63, then back in LOAD with in_ready = 1.
- During UNLOAD toggle out_ready 1,0,0,1 -> cnt and out_data hold while out_ready = 0, with no duplicated or skipped bytes across 64 beats.
- Write lbp_addr = 0 data 0xFF in RUN -> wr_err = 1 and byte 0 unloads as 0x00. Write during LOAD -> wr_err stays 1 and nothing is captured.
- Write addr 18 data 0x11 with finish on the same edge -> byte 18 unloads 0x11 and core_rst = 1 the next cycle.
- Assert reset low after 30 loaded bytes -> in_ready = 1, cnt = 0, core_rst = 1. A full 64-byte reload is required before core_rst falls, and the next UNLOAD shows only the new run's writes.

Source files
------------

// File: rtl/lbp_host_mem.sv
// lbp_host_mem: memory-side responder for the LBP engine.
//   Loads an 8x8 gray image from a byte stream (holding the engine in reset),
//   serves the engine's zero-latency gray reads, captures its interior LBP
//   writes, and on finish streams the 64-byte LBP result image back out.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data        - gray load stream (raster order)
//   core_rst              - active-high reset to the LBP engine
//   gray_addr/gray_req/gray_data     - engine read port
//   lbp_addr/lbp_write/lbp_data      - engine write port
//   finish                - engine done pulse
//   out_valid/out_ready/out_data/out_last - LBP result stream
//   wr_err                - sticky illegal-write flag
module lbp_host_mem #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_data,
  output logic              core_rst,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic [PIX_W-1:0]  gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_write,
  input  logic [PIX_W-1:0]  lbp_data,
  input  logic              finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_last,
  output logic              wr_err
);

  localparam int unsigned DEPTH = IMG_W * IMG_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] EDGE_HI   = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UNLOAD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    mask_q, mask_d;
  logic                core_rst_q, core_rst_d;
  logic                wr_err_q, wr_err_d;

  logic [PIX_W-1:0]    img_mem [DEPTH];
  logic [PIX_W-1:0]    lbp_mem [DEPTH];

  logic [ADDR_W-1:0]   row_c, col_c;
  logic                interior_c;
  logic                load_fire_c;
  logic                lbp_fire_c;

  // Only interior pixels (row and column 1..IMG_W-2) carry a valid LBP code.
  assign row_c      = lbp_addr / ADDR_W'(IMG_W);
  assign col_c      = lbp_addr % ADDR_W'(IMG_W);
  assign interior_c = (row_c != '0) && (row_c != EDGE_HI) &&
                      (col_c != '0) && (col_c != EDGE_HI);

  assign load_fire_c = (state_q == ST_LOAD) && in_valid;
  assign lbp_fire_c  = (state_q == ST_RUN) && lbp_write && interior_c;

  // Next-state and control-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    core_rst_d = core_rst_q;
    wr_err_d   = wr_err_q;

    // Any write that is not captured (border address or wrong phase) is illegal.
    if (lbp_write && !lbp_fire_c) begin
      wr_err_d = 1'b1;
    end

    unique case (state_q)
      ST_LOAD: begin
        core_rst_d = 1'b1;
        if (in_valid) begin
          if (cnt_q == LAST_ADDR) begin
            // Last pixel: release the engine and forget any stale results.
            cnt_d      = '0;
            mask_d     = '0;
            core_rst_d = 1'b0;
            state_d    = ST_RUN;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (lbp_fire_c) begin
          mask_d[lbp_addr] = 1'b1;
        end
        if (finish) begin
          core_rst_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        cnt_d      = '0;
        core_rst_d = 1'b1;
        state_d    = ST_LOAD;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      mask_q     <= '0;
      core_rst_q <= 1'b1;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      core_rst_q <= core_rst_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Image and result storage; contents survive reset, validity is tracked by mask_q.
  always_ff @(posedge clk) begin
    if (load_fire_c) begin
      img_mem[cnt_q] <= in_data;
    end
    if (lbp_fire_c) begin
      lbp_mem[lbp_addr] <= lbp_data;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign gray_data = ((state_q == ST_RUN) && gray_req) ? img_mem[gray_addr] : '0;
  assign out_valid = (state_q == ST_UNLOAD);
  // Unwritten (including all border) positions stream out as zero.
  assign out_data  = ((state_q == ST_UNLOAD) && mask_q[cnt_q]) ? lbp_mem[cnt_q] : '0;
  assign out_last  = (state_q == ST_UNLOAD) && (cnt_q == LAST_ADDR);
  assign core_rst  = core_rst_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_lbp_host_mem.sv
module tb_lbp_host_mem;

  typedef logic [7:0] img_t [64];

  typedef struct {
    logic       req;
    logic [5:0] addr;
    logic [7:0] exp;
  } gvec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       core_rst;
  logic [5:0] gray_addr;
  logic       gray_req;
  logic [7:0] gray_data;
  logic [5:0] lbp_addr;
  logic       lbp_write;
  logic [7:0] lbp_data;
  logic       finish;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       wr_err;

  int total = 0;
  int bad   = 0;

  lbp_host_mem dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .core_rst  (core_rst),
    .gray_addr (gray_addr),
    .gray_req  (gray_req),
    .gray_data (gray_data),
    .lbp_addr  (lbp_addr),
    .lbp_write (lbp_write),
    .lbp_data  (lbp_data),
    .finish    (finish),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beats(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      check("load_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic lbp_wr(input logic [5:0] a, input logic [7:0] d, input logic fin);
    lbp_write = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    finish    = fin;
    tick();
    lbp_write = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic unload(input img_t exp, input bit toggle);
    int  idx = 0;
    int  cyc = 0;
    bit  rdy;
    while (idx < 64 && cyc < 400) begin
      rdy       = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      check("unload_valid", 32'(out_valid), 32'd1);
      check($sformatf("unload_data[%0d]", idx), 32'(out_data), 32'(exp[idx]));
      check($sformatf("unload_last[%0d]", idx), 32'(out_last), 32'(idx == 63));
      tick();
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b1;
    if (idx < 64) check("unload_timeout", 32'(idx), 32'd64);
    check("post_unload_valid", 32'(out_valid), 32'd0);
    check("post_unload_in_ready", 32'(in_ready), 32'd1);
    check("post_unload_core_rst", 32'(core_rst), 32'd1);
    check("post_unload_last", 32'(out_last), 32'd0);
  endtask

  initial begin
    gvec_t gv[6];
    img_t  e;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    gray_addr = 6'd0;
    gray_req  = 1'b1;
    lbp_addr  = '0;
    lbp_write = 1'b0;
    lbp_data  = '0;
    finish    = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_gray_data", 32'(gray_data), 32'd0);
    reset    = 1'b1;
    gray_req = 1'b0;
    tick();

    // Load pixel[i] = i; engine released only on the 64th transfer edge.
    load_beats(0, 63);
    check("load63_core_rst", 32'(core_rst), 32'd1);
    check("load63_in_ready", 32'(in_ready), 32'd1);
    load_beats(63, 1);
    check("load64_core_rst", 32'(core_rst), 32'd0);
    check("load64_in_ready", 32'(in_ready), 32'd0);

    // Gray read vectors.
    gv[0] = '{req: 1'b1, addr: 6'd27, exp: 8'd27};
    gv[1] = '{req: 1'b0, addr: 6'd27, exp: 8'd0};
    gv[2] = '{req: 1'b1, addr: 6'd0,  exp: 8'd0};
    gv[3] = '{req: 1'b1, addr: 6'd63, exp: 8'd63};
    gv[4] = '{req: 1'b1, addr: 6'd9,  exp: 8'd9};
    gv[5] = '{req: 1'b0, addr: 6'd63, exp: 8'd0};
    for (int i = 0; i < 6; i++) begin
      gray_req  = gv[i].req;
      gray_addr = gv[i].addr;
      #1;
      check($sformatf("gray_vec%0d", i), 32'(gray_data), 32'(gv[i].exp));
    end
    gray_req = 1'b0;

    // Run 1: two interior writes, then finish and a full-rate unload.
    lbp_wr(6'd9, 8'hA5, 1'b0);
    lbp_wr(6'd54, 8'h3C, 1'b0);
    check("run1_wr_err", 32'(wr_err), 32'd0);
    check("run1_core_rst", 32'(core_rst), 32'd0);
    pulse_finish();
    check("fin1_core_rst", 32'(core_rst), 32'd1);
    check("fin1_out_valid", 32'(out_valid), 32'd1);
    check("fin1_in_ready", 32'(in_ready), 32'd0);
    e = '{default: 8'h00};
    e[9]  = 8'hA5;
    e[54] = 8'h3C;
    unload(e, 1'b0);

    // Run 2: border write, write coincident with finish, stalled unload.
    load_beats(100, 64);
    check("load2_core_rst", 32'(core_rst), 32'd0);
    gray_req  = 1'b1;
    gray_addr = 6'd27;
    #1;
    check("gray2_addr27", 32'(gray_data), 32'd127);
    gray_req = 1'b0;
    lbp_wr(6'd0, 8'hFF, 1'b0);
    check("border_wr_err", 32'(wr_err), 32'd1);
    check("border_core_rst", 32'(core_rst), 32'd0);
    lbp_wr(6'd18, 8'h11, 1'b1);
    check("wrfin_core_rst", 32'(core_rst), 32'd1);
    check("wrfin_out_valid", 32'(out_valid), 32'd1);
    e = '{default: 8'h00};
    e[18] = 8'h11;
    unload(e, 1'b1);

    // Write outside RUN is ignored; flag stays set, load counter unaffected.
    lbp_wr(6'd20, 8'h77, 1'b0);
    check("load_wr_err", 32'(wr_err), 32'd1);
    check("load_wr_in_ready", 32'(in_ready), 32'd1);
    check("load_wr_core_rst", 32'(core_rst), 32'd1);

    // Partial load then asynchronous reset mid-cycle.
    load_beats(7, 30);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_core_rst", 32'(core_rst), 32'd1);
    check("midrst_wr_err", 32'(wr_err), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;

    // Full reload required before the engine is released.
    load_beats(200, 63);
    check("reload63_core_rst", 32'(core_rst), 32'd1);
    check("reload63_in_ready", 32'(in_ready), 32'd1);
    load_beats(263, 1);
    check("reload64_core_rst", 32'(core_rst), 32'd0);
    check("reload64_in_ready", 32'(in_ready), 32'd0);
    gray_req  = 1'b1;
    gray_addr = 6'd5;
    #1;
    check("gray3_addr5", 32'(gray_data), 32'd205);
    gray_addr = 6'd63;
    #1;
    check("gray3_addr63", 32'(gray_data), 32'd7);
    gray_addr = 6'd27;
    #1;
    check("gray3_addr27", 32'(gray_data), 32'd227);
    gray_req = 1'b0;

    // Run 3: same-address writes back to back, only new results unload.
    lbp_wr(6'd45, 8'h01, 1'b0);
    lbp_wr(6'd45, 8'h02, 1'b0);
    lbp_wr(6'd36, 8'h5A, 1'b0);
    check("run3_wr_err", 32'(wr_err), 32'd0);
    pulse_finish();
    check("fin3_core_rst", 32'(core_rst), 32'd1);
    e = '{default: 8'h00};
    e[45] = 8'h02;
    e[36] = 8'h5A;
    unload(e, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
